// File: rtl/addsub_multicycle.sv
// Chunked add/subtract with carry-in: WIDTH-bit operands are summed CHUNK bits
// per cycle through a registered carry, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// RUN   | summing one chunk per cycle, low chunk first
// DONE  | result held with out_valid high until out_ready
module addsub_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SUB,
    input  logic             CIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             V
);

    localparam int K  = WIDTH / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("addsub_multicycle: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IW-1:0]    idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] o_q,         o_d;
    logic             cout_q,      cout_d;
    logic             v_q,         v_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   sum;
    logic             msb_carry_in;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        o_d         = o_q;
        cout_d      = cout_q;
        v_d         = v_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        chunk_a = '0;
        chunk_b = '0;
        for (int j = 0; j < K; j++) begin
            if (idx_q == IW'(j)) begin
                chunk_a = a_q[j*CHUNK +: CHUNK];
                chunk_b = b_q[j*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of the chunk, recovered from its sum bit.
        msb_carry_in = sum[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = I0;
                    b_d        = SUB ? ~I1 : I1;
                    carry_d    = CIN;
                    idx_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                for (int j = 0; j < K; j++) begin
                    if (idx_q == IW'(j)) begin
                        o_d[j*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                    end
                end
                carry_d = sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d      = sum[CHUNK];
                    v_d         = msb_carry_in ^ sum[CHUNK];
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            o_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            o_q         <= o_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign O         = o_q;
    assign COUT      = cout_q;
    assign V         = v_q;

endmodule
